// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the wait-stated data-memory responder.
//   state_t       : responder FSM state encoding (IDLE=0, ACCESS=1, RESP=2)
//   CNT_WIDTH     : width of the wait-cycle counter
//   WAIT_MAX      : largest supported WAIT_CYCLES value
//   strb_legal    : store strobe patterns the responder accepts
//   strb_low_lane : lowest enabled byte lane of a strobe
//   strb_err      : store strobe / address alignment error
package dmem_responder_pkg;

    localparam int CNT_WIDTH = 4;
    localparam int WAIT_MAX  = 15;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    // Single bytes, naturally aligned halves and the full word.
    // 0000 is a legal no-op store.
    function automatic logic strb_legal(input logic [3:0] strb);
        case (strb)
            4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b1100, 4'b1111: return 1'b1;
            default:                   return 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] strb_low_lane(input logic [3:0] strb);
        casez (strb)
            4'b???1: return 2'd0;
            4'b??10: return 2'd1;
            4'b?100: return 2'd2;
            default: return 2'd3;
        endcase
    endfunction

    // The byte address of a store must point at its lowest enabled lane.
    function automatic logic strb_err(input logic [3:0] strb, input logic [1:0] addr_lo);
        if (strb == 4'b0000) begin
            return 1'b0;
        end
        return !strb_legal(strb) || (strb_low_lane(strb) != addr_lo);
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response channels between a data-memory initiator and the responder.
//   req_*  : request channel (valid/ready), store data lane-aligned
//   rsp_*  : response channel (valid/ready), read data or error
//   master : initiator side, slave : responder side
interface dmem_responder_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                    req_valid;
    logic                    req_ready;
    logic                    req_we;
    logic [DATA_WIDTH/8-1:0] req_strb;
    logic [ADDR_WIDTH-1:0]   req_addr;
    logic [DATA_WIDTH-1:0]   req_wdata;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [DATA_WIDTH-1:0]   rsp_rdata;
    logic                    rsp_err;

    modport master (
        output req_valid, req_we, req_strb, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_strb, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_array.sv
// Backing RAM for the data-memory responder.
// Synchronous write with per-byte enable, synchronous read; no reset on contents.
//   clk   : clock
//   en    : access enable (one cycle per transaction)
//   we    : 1 = write enabled lanes, 0 = read word into rdata
//   be    : byte lane enables for writes
//   widx  : word index
//   wdata : lane-aligned write data
//   rdata : registered read data, held until the next read
module dmem_array #(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH_WORDS = 1024,
    localparam int IDX_W      = $clog2(DEPTH_WORDS),
    localparam int BE_W       = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [BE_W-1:0]       be,
    input  logic [IDX_W-1:0]      widx,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);
    logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < BE_W; i++) begin
                    if (be[i]) begin
                        mem[widx][8*i +: 8] <= wdata[8*i +: 8];
                    end
                end
            end else begin
                rdata <= mem[widx];
            end
        end
    end
endmodule

// File: rtl/dmem_responder.sv
// Wait-stated data RAM responder: one load/store at a time, fixed access latency.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : request/response channels (slave side)
//   busy  : a transaction is in flight
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   IDLE   | req_ready=1, waiting for a request
//   ACCESS | request latched, counting WAIT_CYCLES+1 cycles; RAM op on last
//   RESP   | rsp_valid=1, holding response until rsp_ready
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    dmem_responder_if.slave   bus,
    output logic              busy
);
    localparam int IDX_W  = $clog2(DEPTH_WORDS);
    localparam int WIDX_W = ADDR_WIDTH - 2;
    localparam logic [CNT_WIDTH-1:0] WAIT_LAST = CNT_WIDTH'(WAIT_CYCLES);
    localparam logic [WIDX_W-1:0]    WIDX_LIM  = WIDX_W'(DEPTH_WORDS);

    if (WAIT_CYCLES < 0 || WAIT_CYCLES > WAIT_MAX) begin : g_bad_wait
        $error("dmem_responder: WAIT_CYCLES must be 0..15");
    end
    if (DATA_WIDTH != 32) begin : g_bad_width
        $error("dmem_responder: strobe rules assume a 32-bit data word");
    end
    if (DEPTH_WORDS < 2) begin : g_bad_depth
        $error("dmem_responder: DEPTH_WORDS must be at least 2");
    end

    state_t                 state;
    logic [CNT_WIDTH-1:0]   cnt;
    logic                   lat_we;
    logic [3:0]             lat_strb;
    logic [ADDR_WIDTH-1:0]  lat_addr;
    logic [DATA_WIDTH-1:0]  lat_wdata;
    logic                   req_ready_q;
    logic                   rsp_valid_q;
    logic                   rsp_err_q;
    logic                   rsp_load_q;
    logic                   busy_q;

    logic                   req_err;
    logic                   last_access;
    logic                   ram_en;
    logic [DATA_WIDTH-1:0]  ram_rdata;

    // Range check uses the full word index so out-of-range addresses never
    // alias onto the truncated RAM index.
    assign req_err     = (lat_addr[ADDR_WIDTH-1:2] >= WIDX_LIM) ||
                         (lat_we && strb_err(lat_strb, lat_addr[1:0]));
    assign last_access = (state == ST_ACCESS) && (cnt == WAIT_LAST);
    assign ram_en      = last_access && !req_err;

    dmem_array #(
        .DATA_WIDTH  (DATA_WIDTH),
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .clk   (clk),
        .en    (ram_en),
        .we    (lat_we),
        .be    (lat_strb),
        .widx  (lat_addr[IDX_W+1:2]),
        .wdata (lat_wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            lat_we      <= 1'b0;
            lat_strb    <= '0;
            lat_addr    <= '0;
            lat_wdata   <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_load_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        lat_we      <= bus.req_we;
                        lat_strb    <= bus.req_strb;
                        lat_addr    <= bus.req_addr;
                        lat_wdata   <= bus.req_wdata;
                        cnt         <= '0;
                        state       <= ST_ACCESS;
                        req_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                    end
                end
                ST_ACCESS: begin
                    if (cnt == WAIT_LAST) begin
                        state       <= ST_RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= req_err;
                        rsp_load_q  <= !lat_we && !req_err;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        state       <= ST_IDLE;
                        rsp_valid_q <= 1'b0;
                        rsp_err_q   <= 1'b0;
                        rsp_load_q  <= 1'b0;
                        req_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // The RAM read register is written only in the last ACCESS cycle, so it
    // stays stable for the whole RESP phase; stores and errors read as zero.
    assign bus.rsp_rdata = rsp_load_q ? ram_rdata : '0;
    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign busy          = busy_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios plus randomized
// traffic against a word-array reference model (WAIT_CYCLES=2 and 0 instances).
module tb_dmem_responder;
    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int DEPTH = 1024;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        v2, v0, t_we, t_rsp_ready;
    logic [3:0]  t_strb;
    logic [31:0] t_addr, t_wdata;
    logic        busy2, busy0;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [31:0] model_mem [16];

    dmem_responder_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus2 ();
    dmem_responder_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus0 ();

    assign bus2.req_valid = v2;
    assign bus2.req_we    = t_we;
    assign bus2.req_strb  = t_strb;
    assign bus2.req_addr  = t_addr;
    assign bus2.req_wdata = t_wdata;
    assign bus2.rsp_ready = t_rsp_ready;
    assign bus0.req_valid = v0;
    assign bus0.req_we    = t_we;
    assign bus0.req_strb  = t_strb;
    assign bus0.req_addr  = t_addr;
    assign bus0.req_wdata = t_wdata;
    assign bus0.rsp_ready = t_rsp_ready;

    dmem_responder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2), .busy(busy2));
    dmem_responder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0), .busy(busy0));

    // Initiator must hold the request stable while it is stalled.
    a_req_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (bus2.req_valid && !bus2.req_ready) |=> $stable({bus2.req_we, bus2.req_strb, bus2.req_addr, bus2.req_wdata}))
        else $error("FAIL req_hold: request fields changed while stalled");

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference error rule, written from the list of legal strobes.
    function automatic bit ref_err(bit we, logic [3:0] strb, logic [31:0] addr);
        logic [3:0] legal [7] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
        bit listed = 0;
        int lowest = -1;
        if ((addr >> 2) >= DEPTH) return 1;
        if (!we || strb == 4'b0000) return 0;
        foreach (legal[i]) if (legal[i] == strb) listed = 1;
        for (int i = 3; i >= 0; i--) if (strb[i]) lowest = i;
        return !listed || (lowest != int'(addr[1:0]));
    endfunction

    task automatic start_req(input bit use0, input bit we, input logic [3:0] strb,
                             input logic [31:0] addr, input logic [31:0] wdata);
        int n = 0;
        @(negedge clk);
        t_we = we; t_strb = strb; t_addr = addr; t_wdata = wdata;
        if (use0) v0 = 1'b1; else v2 = 1'b1;
        while (((use0 ? bus0.req_ready : bus2.req_ready) !== 1'b1) && n < 40) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        v0 = 1'b0;
        v2 = 1'b0;
    endtask

    // Counts edges from the accept edge to rsp_valid, then completes the response.
    task automatic finish_rsp(input bit use0, input int hold, output logic [31:0] rd,
                              output logic er, output int lat);
        lat = 0;
        rd  = 'x;
        er  = 1'bx;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while ((use0 ? bus0.rsp_valid : bus2.rsp_valid) !== 1'b1 && lat < 40);
        if ((use0 ? bus0.rsp_valid : bus2.rsp_valid) !== 1'b1) begin
            lat = 99;
            return;
        end
        repeat (hold) begin
            @(posedge clk);
            #1;
        end
        rd = use0 ? bus0.rsp_rdata : bus2.rsp_rdata;
        er = use0 ? bus0.rsp_err : bus2.rsp_err;
        t_rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        t_rsp_ready = 1'b0;
    endtask

    task automatic txn(input bit use0, input int hold, input bit we, input logic [3:0] strb,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rd, output logic er, output int lat);
        start_req(use0, we, strb, addr, wdata);
        finish_rsp(use0, hold, rd, er, lat);
    endtask

    task automatic test_reset();
        tests_run++;
        if (bus2.req_ready !== 1'b1 || bus2.rsp_valid !== 1'b0 || busy2 !== 1'b0 ||
            bus2.rsp_err !== 1'b0 || bus2.rsp_rdata !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_state: ready=%b valid=%b busy=%b err=%b rdata=%h, want 1 0 0 0 0",
                     bus2.req_ready, bus2.rsp_valid, busy2, bus2.rsp_err, bus2.rsp_rdata);
        end
    endtask

    task automatic test_store_load();
        logic [31:0] rd; logic er; int lat;
        txn(0, 0, 1, 4'b1111, 32'h10, 32'hDEADBEEF, rd, er, lat);
        tests_run++;
        if (lat !== 3 || er !== 1'b0 || rd !== 32'h0) begin
            tests_failed++;
            $display("FAIL store_full: lat=%0d err=%b rdata=%h, want 3 0 00000000", lat, er, rd);
        end
        txn(0, 0, 0, 4'b0000, 32'h10, 32'h0, rd, er, lat);
        tests_run++;
        if (lat !== 3 || er !== 1'b0 || rd !== 32'hDEADBEEF) begin
            tests_failed++;
            $display("FAIL load_full: lat=%0d err=%b rdata=%h, want 3 0 deadbeef", lat, er, rd);
        end
        // Lane 1 store: data sits in bits [15:8].
        txn(0, 0, 1, 4'b0010, 32'h11, 32'h0000AA00, rd, er, lat);
        txn(0, 0, 0, 4'b0000, 32'h10, 32'h0, rd, er, lat);
        tests_run++;
        if (er !== 1'b0 || rd !== 32'hDEADAAEF) begin
            tests_failed++;
            $display("FAIL store_byte1: err=%b rdata=%h, want 0 deadaaef", er, rd);
        end
    endtask

    task automatic test_merge_and_strobe_err();
        logic [31:0] rd; logic er; int lat;
        txn(0, 0, 1, 4'b1100, 32'h12, 32'h12340000, rd, er, lat);
        txn(0, 0, 0, 4'b0000, 32'h13, 32'h0, rd, er, lat);
        tests_run++;
        if (er !== 1'b0 || rd !== 32'h1234AAEF) begin
            tests_failed++;
            $display("FAIL store_upper_half: err=%b rdata=%h, want 0 1234aaef", er, rd);
        end
        txn(0, 0, 1, 4'b0101, 32'h13, 32'hFFFFFFFF, rd, er, lat);
        tests_run++;
        if (lat !== 3 || er !== 1'b1 || rd !== 32'h0) begin
            tests_failed++;
            $display("FAIL strobe_illegal: lat=%0d err=%b rdata=%h, want 3 1 00000000", lat, er, rd);
        end
        txn(0, 0, 1, 4'b0001, 32'h11, 32'hFFFFFFFF, rd, er, lat);
        tests_run++;
        if (er !== 1'b1) begin
            tests_failed++;
            $display("FAIL strobe_misaligned: err=%b, want 1", er);
        end
        txn(0, 0, 1, 4'b0000, 32'h12, 32'hFFFFFFFF, rd, er, lat);
        tests_run++;
        if (er !== 1'b0 || rd !== 32'h0) begin
            tests_failed++;
            $display("FAIL store_noop: err=%b rdata=%h, want 0 00000000", er, rd);
        end
        txn(0, 0, 0, 4'b0000, 32'h10, 32'h0, rd, er, lat);
        tests_run++;
        if (rd !== 32'h1234AAEF) begin
            tests_failed++;
            $display("FAIL ram_unchanged_after_err: rdata=%h, want 1234aaef", rd);
        end
    endtask

    task automatic test_range();
        logic [31:0] rd; logic er; int lat;
        txn(0, 0, 1, 4'b1111, 32'h0, 32'h5A5A0001, rd, er, lat);
        txn(0, 0, 0, 4'b0000, 32'h1000, 32'h0, rd, er, lat);
        tests_run++;
        if (er !== 1'b1 || rd !== 32'h0) begin
            tests_failed++;
            $display("FAIL load_out_of_range: err=%b rdata=%h, want 1 00000000", er, rd);
        end
        txn(0, 0, 1, 4'b1111, 32'h1000, 32'hFFFFFFFF, rd, er, lat);
        tests_run++;
        if (er !== 1'b1 || rd !== 32'h0) begin
            tests_failed++;
            $display("FAIL store_out_of_range: err=%b rdata=%h, want 1 00000000", er, rd);
        end
        txn(0, 0, 0, 4'b0000, 32'h0, 32'h0, rd, er, lat);
        tests_run++;
        if (er !== 1'b0 || rd !== 32'h5A5A0001) begin
            tests_failed++;
            $display("FAIL no_alias_word0: err=%b rdata=%h, want 0 5a5a0001", er, rd);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] rd; logic er; int lat; int n = 0; int bad = 0;
        start_req(0, 0, 4'b0000, 32'h10, 32'h0);
        while (bus2.rsp_valid !== 1'b1 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        @(negedge clk);
        t_we = 1; t_strb = 4'b1111; t_addr = 32'h14; t_wdata = 32'h00000077;
        v2 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (bus2.rsp_valid !== 1'b1 || bus2.rsp_rdata !== 32'h1234AAEF || bus2.req_ready !== 1'b0) bad++;
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL resp_hold: %0d of 5 stalled cycles wrong (valid=%b rdata=%h ready=%b), want 0",
                     bad, bus2.rsp_valid, bus2.rsp_rdata, bus2.req_ready);
        end
        t_rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        t_rsp_ready = 1'b0;
        tests_run++;
        if (bus2.rsp_valid !== 1'b0 || bus2.req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL resp_release: valid=%b ready=%b, want 0 1", bus2.rsp_valid, bus2.req_ready);
        end
        @(posedge clk);
        #1;
        v2 = 1'b0;
        tests_run++;
        if (bus2.req_ready !== 1'b0 || busy2 !== 1'b1) begin
            tests_failed++;
            $display("FAIL pending_accept: ready=%b busy=%b, want 0 1", bus2.req_ready, busy2);
        end
        finish_rsp(0, 0, rd, er, lat);
        txn(0, 0, 0, 4'b0000, 32'h14, 32'h0, rd, er, lat);
        tests_run++;
        if (rd !== 32'h00000077 || er !== 1'b0) begin
            tests_failed++;
            $display("FAIL pending_store_data: err=%b rdata=%h, want 0 00000077", er, rd);
        end
    endtask

    task automatic test_reset_mid_access();
        logic [31:0] rd; logic er; int lat; int bad = 0;
        txn(0, 0, 1, 4'b1111, 32'h20, 32'h11112222, rd, er, lat);
        start_req(0, 1, 4'b1111, 32'h20, 32'hCAFEF00D);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (bus2.req_ready !== 1'b1 || bus2.rsp_valid !== 1'b0 || busy2 !== 1'b0 ||
            bus2.rsp_err !== 1'b0 || bus2.rsp_rdata !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_async: ready=%b valid=%b busy=%b err=%b rdata=%h, want 1 0 0 0 0",
                     bus2.req_ready, bus2.rsp_valid, busy2, bus2.rsp_err, bus2.rsp_rdata);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (bus2.rsp_valid !== 1'b0) bad++;
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL reset_no_response: rsp_valid high in %0d cycles, want 0", bad);
        end
        txn(0, 0, 0, 4'b0000, 32'h20, 32'h0, rd, er, lat);
        tests_run++;
        if (rd !== 32'h11112222) begin
            tests_failed++;
            $display("FAIL reset_write_abandoned: rdata=%h, want 11112222", rd);
        end
    endtask

    task automatic test_wait0();
        logic [31:0] rd; logic er; int lat;
        txn(1, 0, 1, 4'b1111, 32'h30, 32'hA1B2C3D4, rd, er, lat);
        tests_run++;
        if (lat !== 1 || er !== 1'b0 || rd !== 32'h0) begin
            tests_failed++;
            $display("FAIL w0_store: lat=%0d err=%b rdata=%h, want 1 0 00000000", lat, er, rd);
        end
        // rsp_ready already high when the response appears.
        t_rsp_ready = 1'b1;
        txn(1, 0, 0, 4'b0000, 32'h31, 32'h0, rd, er, lat);
        tests_run++;
        if (lat !== 1 || rd !== 32'hA1B2C3D4 || bus0.rsp_valid !== 1'b0 || bus0.req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL w0_load_preready: lat=%0d rdata=%h valid=%b ready=%b, want 1 a1b2c3d4 0 1",
                     lat, rd, bus0.rsp_valid, bus0.req_ready);
        end
        txn(1, 0, 1, 4'b1000, 32'h30, 32'hFF000000, rd, er, lat);
        tests_run++;
        if (lat !== 1 || er !== 1'b1) begin
            tests_failed++;
            $display("FAIL w0_misaligned: lat=%0d err=%b, want 1 1", lat, er);
        end
    endtask

    task automatic test_random();
        logic [3:0] legal [7] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
        logic [31:0] rd, addr, wdata, exp_rd; logic er; int lat;
        logic [3:0] strb; bit we, exp_er; int idx;
        for (int w = 0; w < 16; w++) begin
            model_mem[w] = $urandom;
            txn(0, 0, 1, 4'b1111, 32'(w * 4), model_mem[w], rd, er, lat);
            tests_run++;
            if (er !== 1'b0 || lat !== 3) begin
                tests_failed++;
                $display("FAIL rand_init[%0d]: err=%b lat=%0d, want 0 3", w, er, lat);
            end
        end
        for (int t = 0; t < 80; t++) begin
            we    = $urandom_range(0, 1) == 1;
            wdata = $urandom;
            strb  = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 9) == 0) addr = 32'((DEPTH + $urandom_range(0, 4095)) * 4 + $urandom_range(0, 3));
            else                          addr = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
            if (we && $urandom_range(0, 1) == 1) begin
                strb = legal[$urandom_range(0, 6)];
                for (int i = 3; i >= 0; i--) if (strb[i]) addr[1:0] = 2'(i);
            end
            exp_er = ref_err(we, strb, addr);
            idx    = int'(addr >> 2);
            exp_rd = (!we && !exp_er) ? model_mem[idx] : 32'h0;
            if (we && !exp_er) begin
                for (int i = 0; i < 4; i++) if (strb[i]) model_mem[idx][8*i +: 8] = wdata[8*i +: 8];
            end
            txn(0, $urandom_range(0, 2), we, strb, addr, wdata, rd, er, lat);
            tests_run++;
            if (lat !== 3 || er !== exp_er || rd !== exp_rd) begin
                tests_failed++;
                $display("FAIL rand[%0d] we=%0d strb=%b addr=%h: lat=%0d err=%b rdata=%h, want 3 %0d %h",
                         t, we, strb, addr, lat, er, rd, exp_er, exp_rd);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        v2 = 1'b0; v0 = 1'b0; t_we = 1'b0; t_strb = '0; t_addr = '0; t_wdata = '0;
        t_rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_store_load();
        test_merge_and_strobe_err();
        test_range();
        test_backpressure();
        test_reset_mid_access();
        test_wait0();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
